control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_pkg.sv | 110 +++++++++++
 rtl/ctrl_decode.sv | 27 ++
 rtl/control_sequencer.sv | 128 ++++++++++++
 tb/tb_control_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// control_pkg: shared definitions for the control sequencer.
//   - opcode localparams (5-bit base encoding)
//   - FSM state enum
//   - ctrl_t packed control bundle (alu_ctrl at table width TBL_ALUW) and CTRL_W
//   - ctrl_table(): opcode -> control fields; unlisted fields are 0
package control_pkg;

   localparam int TBL_ALUW = 4;

   localparam logic [4:0] OP_NOP   = 5'b00000;
   localparam logic [4:0] OP_HLT   = 5'b00001;
   localparam logic [4:0] OP_SETC  = 5'b00010;
   localparam logic [4:0] OP_CLRC  = 5'b00011;
   localparam logic [4:0] OP_NOT   = 5'b00100;
   localparam logic [4:0] OP_INC   = 5'b00101;
   localparam logic [4:0] OP_DEC   = 5'b00110;
   localparam logic [4:0] OP_OUT   = 5'b00111;
   localparam logic [4:0] OP_IN    = 5'b01000;
   localparam logic [4:0] OP_ADD   = 5'b01001;
   localparam logic [4:0] OP_SUB   = 5'b01010;
   localparam logic [4:0] OP_AND   = 5'b01011;
   localparam logic [4:0] OP_OR    = 5'b01100;
   localparam logic [4:0] OP_SHL   = 5'b01101;
   localparam logic [4:0] OP_SHR   = 5'b01110;
   localparam logic [4:0] OP_MOV   = 5'b01111;
   localparam logic [4:0] OP_PUSH  = 5'b10000;
   localparam logic [4:0] OP_POP   = 5'b10001;
   localparam logic [4:0] OP_LDM   = 5'b10010;
   localparam logic [4:0] OP_LDD   = 5'b10011;
   localparam logic [4:0] OP_STD   = 5'b10100;
   localparam logic [4:0] OP_JZ    = 5'b10101;
   localparam logic [4:0] OP_JN    = 5'b10110;
   localparam logic [4:0] OP_JMP   = 5'b10111;
   localparam logic [4:0] OP_CALL  = 5'b11000;
   localparam logic [4:0] OP_CALL2 = 5'b11001;
   localparam logic [4:0] OP_RET   = 5'b11010;
   localparam logic [4:0] OP_RET2  = 5'b11011;
   localparam logic [4:0] OP_RTI   = 5'b11100;
   localparam logic [4:0] OP_RTI2  = 5'b11101;
   localparam logic [4:0] OP_INT1  = 5'b11110;
   localparam logic [4:0] OP_INT2  = 5'b11111;

   typedef enum logic [2:0] {ST_IDLE, ST_CALL2, ST_RET2, ST_RTI2, ST_INT2} state_t;

   typedef struct packed {
      logic [1:0]          sp_op;
      logic                reg_write;
      logic                mem_read;
      logic                mem_write;
      logic                mem_or_reg;
      logic                update_status;
      logic                imm_or_reg;
      logic [TBL_ALUW-1:0] alu_ctrl;
      logic                sp_or_alu;
      logic                dest_or_private;
      logic                branch;
      logic [1:0]          carry_ctl;
      logic                pc_ctrl;
      logic                priv_reg_write;
      logic [1:0]          fct;
      logic                interrupt;
   } ctrl_t;

   localparam int CTRL_W = $bits(ctrl_t);

   function automatic ctrl_t ctrl_table(input logic [4:0] op);
      ctrl_t c;
      c = '0;
      case (op)
         OP_HLT:  c.pc_ctrl = 1'b1;
         OP_SETC: c.carry_ctl = 2'b01;
         OP_CLRC: c.carry_ctl = 2'b10;
         OP_NOT:  begin c.reg_write = 1'b1; c.update_status = 1'b1; c.alu_ctrl = 4'b0001; end
         OP_INC:  begin c.reg_write = 1'b1; c.update_status = 1'b1; c.alu_ctrl = 4'b0010; end
         OP_DEC:  begin c.reg_write = 1'b1; c.update_status = 1'b1; c.alu_ctrl = 4'b0011; end
         OP_OUT:  c.alu_ctrl = 4'b1111;
         OP_IN:   c.reg_write = 1'b1;
         OP_ADD:  begin c.reg_write = 1'b1; c.update_status = 1'b1; c.alu_ctrl = 4'b0000; end
         OP_SUB:  begin c.reg_write = 1'b1; c.update_status = 1'b1; c.alu_ctrl = 4'b0100; end
         OP_AND:  begin c.reg_write = 1'b1; c.update_status = 1'b1; c.alu_ctrl = 4'b0101; end
         OP_OR:   begin c.reg_write = 1'b1; c.update_status = 1'b1; c.alu_ctrl = 4'b0110; end
         OP_SHL:  begin c.reg_write = 1'b1; c.update_status = 1'b1; c.imm_or_reg = 1'b1;
                        c.alu_ctrl = 4'b0111; end
         OP_SHR:  begin c.reg_write = 1'b1; c.update_status = 1'b1; c.imm_or_reg = 1'b1;
                        c.alu_ctrl = 4'b1000; end
         OP_MOV:  begin c.reg_write = 1'b1; c.alu_ctrl = 4'b1001; end
         OP_PUSH: begin c.sp_op = 2'b01; c.mem_write = 1'b1; c.sp_or_alu = 1'b1; end
         OP_POP:  begin c.sp_op = 2'b10; c.mem_read = 1'b1; c.reg_write = 1'b1;
                        c.mem_or_reg = 1'b1; c.sp_or_alu = 1'b1; end
         OP_LDM:  begin c.reg_write = 1'b1; c.imm_or_reg = 1'b1; c.alu_ctrl = 4'b1001; end
         OP_LDD:  begin c.reg_write = 1'b1; c.mem_read = 1'b1; c.mem_or_reg = 1'b1;
                        c.imm_or_reg = 1'b1; end
         OP_STD:  begin c.mem_write = 1'b1; c.imm_or_reg = 1'b1; end
         OP_JZ:   begin c.branch = 1'b1; c.fct = 2'b01; end
         OP_JN:   begin c.branch = 1'b1; c.fct = 2'b10; end
         OP_JMP, OP_CALL2: begin c.branch = 1'b1; c.fct = 2'b11; end
         OP_CALL, OP_INT1: begin c.sp_op = 2'b01; c.mem_write = 1'b1; c.sp_or_alu = 1'b1;
                                 c.dest_or_private = 1'b1; c.priv_reg_write = 1'b1;
                                 c.interrupt = (op == OP_INT1); end
         OP_RET, OP_RTI:   begin c.sp_op = 2'b10; c.mem_read = 1'b1; c.sp_or_alu = 1'b1;
                                 c.dest_or_private = 1'b1; c.priv_reg_write = 1'b1; end
         OP_RET2: begin c.pc_ctrl = 1'b1; c.mem_or_reg = 1'b1; end
         OP_RTI2: begin c.pc_ctrl = 1'b1; c.mem_or_reg = 1'b1; c.carry_ctl = 2'b11; end
         OP_INT2: begin c.branch = 1'b1; c.pc_ctrl = 1'b1; end
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode -> control bundle decoder.
//   opcode       in   OPW   opcode to decode (low 5 bits index the table)
//   ctrl         out  bundle with alu_ctrl zero-extended to ALUW
//   out_of_range out  1     opcode value >= 32
module ctrl_decode
   import control_pkg::*;
#(
   parameter int OPW  = 5,
   parameter int ALUW = 4
) (
   input  logic [OPW-1:0]                   opcode,
   output logic [CTRL_W-TBL_ALUW+ALUW-1:0]  ctrl,
   output logic                             out_of_range
);

   ctrl_t t;

   always_comb begin
      t = ctrl_table(opcode[4:0]);
      ctrl = {t.sp_op, t.reg_write, t.mem_read, t.mem_write, t.mem_or_reg,
              t.update_status, t.imm_or_reg, ALUW'(t.alu_ctrl), t.sp_or_alu,
              t.dest_or_private, t.branch, t.carry_ctl, t.pc_ctrl,
              t.priv_reg_write, t.fct, t.interrupt};
      out_of_range = (opcode >> 5) != '0;
   end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: registered control-word sequencer with two-part
// CALL/RET/RTI and interrupt injection.
//   clk, rst_n   clock, synchronous active-low reset
//   opcode, instr_valid   instruction from fetch/decode
//   stall, flush, int_req pipeline hold, squash, level interrupt request
//   ctrl_o, ctrl_valid    registered control bundle and its valid flag
//   fetch_hold, int_ack, illegal   PC hold, interrupt start pulse, illegal flag
module control_sequencer
   import control_pkg::*;
#(
   parameter int OPW    = 5,
   parameter int ALUW   = 4,
   parameter bit INT_EN = 1'b1
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [OPW-1:0]                  opcode,
   input  logic                            instr_valid,
   input  logic                            stall,
   input  logic                            flush,
   input  logic                            int_req,
   output logic [CTRL_W-TBL_ALUW+ALUW-1:0] ctrl_o,
   output logic                            ctrl_valid,
   output logic                            fetch_hold,
   output logic                            int_ack,
   output logic                            illegal
);

   localparam int OW = CTRL_W - TBL_ALUW + ALUW;

   state_t         state_q, state_d;
   logic [OW-1:0]  ctrl_q, ctrl_d, dec_ctrl;
   logic           valid_q, valid_d, hold_q, hold_d, ack_q, ack_d, ill_q, ill_d;
   logic [OPW-1:0] dec_op;
   logic           dec_oor;
   logic           int_take;
   logic [4:0]     op5;

   assign int_take = INT_EN && int_req;
   assign op5      = opcode[4:0];

   // The single decoder is shared: the second halves of multi-cycle
   // sequences are fed to it as internal opcodes.
   always_comb begin
      dec_op = opcode;
      case (state_q)
         ST_IDLE:  if (int_take) dec_op = OPW'(OP_INT1);
         ST_CALL2: dec_op = OPW'(OP_CALL2);
         ST_RET2:  dec_op = OPW'(OP_RET2);
         ST_RTI2:  dec_op = OPW'(OP_RTI2);
         ST_INT2:  dec_op = OPW'(OP_INT2);
         default:  ;
      endcase
   end

   ctrl_decode #(.OPW(OPW), .ALUW(ALUW)) u_decode (
      .opcode       (dec_op),
      .ctrl         (dec_ctrl),
      .out_of_range (dec_oor)
   );

   always_comb begin
      state_d = state_q;
      ctrl_d  = ctrl_q;
      valid_d = valid_q;
      hold_d  = hold_q;
      ill_d   = ill_q;
      ack_d   = 1'b0;
      if (!stall) begin
         // Baseline: issue the decoded word and return to IDLE; the
         // branches below only override what differs.
         ctrl_d  = dec_ctrl;
         valid_d = 1'b1;
         hold_d  = 1'b0;
         ill_d   = 1'b0;
         state_d = ST_IDLE;
         if (flush && state_q != ST_INT2) begin
            ctrl_d  = '0;
            valid_d = 1'b0;
         end else if (state_q == ST_IDLE) begin
            if (int_take) begin
               hold_d  = 1'b1;
               ack_d   = 1'b1;
               state_d = ST_INT2;
            end else if (!instr_valid) begin
               ctrl_d  = '0;
               valid_d = 1'b0;
            end else if (dec_oor ||
                         op5 inside {OP_CALL2, OP_RET2, OP_RTI2, OP_INT1, OP_INT2}) begin
               ctrl_d = '0;
               ill_d  = 1'b1;
            end else begin
               case (op5)
                  OP_CALL: begin hold_d = 1'b1; state_d = ST_CALL2; end
                  OP_RET:  begin hold_d = 1'b1; state_d = ST_RET2;  end
                  OP_RTI:  begin hold_d = 1'b1; state_d = ST_RTI2;  end
                  default: ;
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ctrl_q  <= '0;
         valid_q <= 1'b0;
         hold_q  <= 1'b0;
         ack_q   <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
         valid_q <= valid_d;
         hold_q  <= hold_d;
         ack_q   <= ack_d;
         ill_q   <= ill_d;
      end
   end

   assign ctrl_o     = ctrl_q;
   assign ctrl_valid = valid_q;
   assign fetch_hold = hold_q;
   assign int_ack    = ack_q;
   assign illegal    = ill_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: bench for control_sequencer (OPW=6, ALUW=4, INT_EN=1).
// A queue-based reference model predicts every registered output each cycle;
// directed steps pin key field values with literals, then random traffic runs.
module tb_control_sequencer;

   logic        clk = 1'b0;
   logic        rst_n, instr_valid, stall, flush, int_req;
   logic [5:0]  opcode;
   logic [21:0] ctrl_o;
   logic        ctrl_valid, fetch_hold, int_ack, illegal;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   control_sequencer #(.OPW(6), .ALUW(4), .INT_EN(1'b1)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .opcode      (opcode),
      .instr_valid (instr_valid),
      .stall       (stall),
      .flush       (flush),
      .int_req     (int_req),
      .ctrl_o      (ctrl_o),
      .ctrl_valid  (ctrl_valid),
      .fetch_hold  (fetch_hold),
      .int_ack     (int_ack),
      .illegal     (illegal)
   );

   // Field order: sp_op, rw, mr, mw, mor, us, ir, alu, soa, dop, br, cc, pc, prw, fct, intr
   function automatic logic [21:0] mk(input logic [1:0] sp, input logic rw, mr, mw, mor, us, ir,
                                      input logic [3:0] alu, input logic soa, dop, br,
                                      input logic [1:0] cc, input logic pc, prw,
                                      input logic [1:0] fct, input logic intr);
      return {sp, rw, mr, mw, mor, us, ir, alu, soa, dop, br, cc, pc, prw, fct, intr};
   endfunction

   function automatic logic [21:0] exp_ctrl(input int op);
      case (op)
         1:  return mk(0,0,0,0,0,0,0,4'd0, 0,0,0,2'd0,1,0,2'd0,0);
         2:  return mk(0,0,0,0,0,0,0,4'd0, 0,0,0,2'd1,0,0,2'd0,0);
         3:  return mk(0,0,0,0,0,0,0,4'd0, 0,0,0,2'd2,0,0,2'd0,0);
         4:  return mk(0,1,0,0,0,1,0,4'd1, 0,0,0,2'd0,0,0,2'd0,0);
         5:  return mk(0,1,0,0,0,1,0,4'd2, 0,0,0,2'd0,0,0,2'd0,0);
         6:  return mk(0,1,0,0,0,1,0,4'd3, 0,0,0,2'd0,0,0,2'd0,0);
         7:  return mk(0,0,0,0,0,0,0,4'd15,0,0,0,2'd0,0,0,2'd0,0);
         8:  return mk(0,1,0,0,0,0,0,4'd0, 0,0,0,2'd0,0,0,2'd0,0);
         9:  return mk(0,1,0,0,0,1,0,4'd0, 0,0,0,2'd0,0,0,2'd0,0);
         10: return mk(0,1,0,0,0,1,0,4'd4, 0,0,0,2'd0,0,0,2'd0,0);
         11: return mk(0,1,0,0,0,1,0,4'd5, 0,0,0,2'd0,0,0,2'd0,0);
         12: return mk(0,1,0,0,0,1,0,4'd6, 0,0,0,2'd0,0,0,2'd0,0);
         13: return mk(0,1,0,0,0,1,1,4'd7, 0,0,0,2'd0,0,0,2'd0,0);
         14: return mk(0,1,0,0,0,1,1,4'd8, 0,0,0,2'd0,0,0,2'd0,0);
         15: return mk(0,1,0,0,0,0,0,4'd9, 0,0,0,2'd0,0,0,2'd0,0);
         16: return mk(1,0,0,1,0,0,0,4'd0, 1,0,0,2'd0,0,0,2'd0,0);
         17: return mk(2,1,1,0,1,0,0,4'd0, 1,0,0,2'd0,0,0,2'd0,0);
         18: return mk(0,1,0,0,0,0,1,4'd9, 0,0,0,2'd0,0,0,2'd0,0);
         19: return mk(0,1,1,0,1,0,1,4'd0, 0,0,0,2'd0,0,0,2'd0,0);
         20: return mk(0,0,0,1,0,0,1,4'd0, 0,0,0,2'd0,0,0,2'd0,0);
         21: return mk(0,0,0,0,0,0,0,4'd0, 0,0,1,2'd0,0,0,2'd1,0);
         22: return mk(0,0,0,0,0,0,0,4'd0, 0,0,1,2'd0,0,0,2'd2,0);
         23: return mk(0,0,0,0,0,0,0,4'd0, 0,0,1,2'd0,0,0,2'd3,0);
         24: return mk(1,0,0,1,0,0,0,4'd0, 1,1,0,2'd0,0,1,2'd0,0);
         25: return mk(0,0,0,0,0,0,0,4'd0, 0,0,1,2'd0,0,0,2'd3,0);
         26: return mk(2,0,1,0,0,0,0,4'd0, 1,1,0,2'd0,0,1,2'd0,0);
         27: return mk(0,0,0,0,1,0,0,4'd0, 0,0,0,2'd0,1,0,2'd0,0);
         28: return mk(2,0,1,0,0,0,0,4'd0, 1,1,0,2'd0,0,1,2'd0,0);
         29: return mk(0,0,0,0,1,0,0,4'd0, 0,0,0,2'd3,1,0,2'd0,0);
         30: return mk(1,0,0,1,0,0,0,4'd0, 1,1,0,2'd0,0,1,2'd0,1);
         31: return mk(0,0,0,0,0,0,0,4'd0, 0,0,1,2'd0,1,0,2'd0,0);
         default: return '0;
      endcase
   endfunction

   // Reference model: pend holds the second half still owed by the sequencer.
   logic [21:0] m_ctrl;
   logic        m_valid, m_hold, m_ack, m_ill;
   bit          known = 1'b0;
   int          pend[$];

   task automatic m_issue(input int op, input logic hold, ack);
      m_ctrl = exp_ctrl(op); m_valid = 1'b1; m_hold = hold; m_ack = ack; m_ill = 1'b0;
   endtask

   task automatic m_bubble(input logic v, ill);
      m_ctrl = '0; m_valid = v; m_hold = 1'b0; m_ack = 1'b0; m_ill = ill;
   endtask

   always @(posedge clk) begin
      int op;
      op = int'(opcode);
      if (!rst_n) begin
         m_bubble(1'b0, 1'b0);
         pend.delete();
         known = 1'b1;
      end else if (stall) begin
         m_ack = 1'b0;
      end else if (flush && !(pend.size() > 0 && pend[0] == 31)) begin
         m_bubble(1'b0, 1'b0);
         pend.delete();
      end else if (pend.size() > 0) begin
         m_issue(pend.pop_front(), 1'b0, 1'b0);
      end else if (int_req) begin
         m_issue(30, 1'b1, 1'b1);
         pend.push_back(31);
      end else if (!instr_valid) begin
         m_bubble(1'b0, 1'b0);
      end else if (op >= 32 || op == 25 || op == 27 || op == 29 || op == 30 || op == 31) begin
         m_bubble(1'b1, 1'b1);
      end else if (op == 24 || op == 26 || op == 28) begin
         m_issue(op, 1'b1, 1'b0);
         pend.push_back(op + 1);
      end else begin
         m_issue(op, 1'b0, 1'b0);
      end
   end

   always @(negedge clk) begin
      if (known) begin
         n_chk++;
         if ({ctrl_o, ctrl_valid, fetch_hold, int_ack, illegal} !==
             {m_ctrl, m_valid, m_hold, m_ack, m_ill}) begin
            n_fail++;
            $display("FAIL cycle_cmp t=%0t got ctrl=%h v=%b h=%b a=%b i=%b expected ctrl=%h v=%b h=%b a=%b i=%b",
                     $time, ctrl_o, ctrl_valid, fetch_hold, int_ack, illegal,
                     m_ctrl, m_valid, m_hold, m_ack, m_ill);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Apply inputs just after a rising edge; outputs are then read #1 after the next one.
   task automatic step(input logic v, input logic [5:0] op, input logic st, fl, ir, rs);
      instr_valid = v; opcode = op; stall = st; flush = fl; int_req = ir; rst_n = rs;
      @(posedge clk); #1;
   endtask

   initial begin
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      check("reset_outputs", 32'({ctrl_o, ctrl_valid, fetch_hold, int_ack, illegal}), 32'd0);

      step(1, 6'd9, 0, 0, 0, 1);
      check("add_ctrl", 32'(ctrl_o), 32'h088000);
      check("add_valid_hold", 32'({ctrl_valid, fetch_hold}), 32'b10);

      step(1, 6'd24, 0, 0, 0, 1);
      check("call1_prw_sp_hold", 32'({ctrl_o[3], ctrl_o[21:20], fetch_hold}), 32'b1011);
      step(1, 6'd9, 0, 0, 0, 1);
      check("call2_br_fct_hold", 32'({ctrl_o[7], ctrl_o[2:1], fetch_hold}), 32'b1110);
      step(0, 6'd0, 0, 0, 0, 1);
      check("after_call_bubble", 32'({ctrl_o, ctrl_valid}), 32'd0);

      step(1, 6'd26, 0, 0, 1, 1);
      check("int1_ack_hold_intr", 32'({int_ack, fetch_hold, ctrl_o[0]}), 32'b111);
      step(1, 6'd26, 0, 1, 0, 1);
      check("int2_not_flushed", 32'({ctrl_o[0], ctrl_o[7], ctrl_o[4], ctrl_valid, int_ack}), 32'b01110);
      step(1, 6'd26, 0, 0, 0, 1);
      check("ret1_after_int", 32'({fetch_hold, ctrl_o[21:20]}), 32'b110);
      step(0, 6'd0, 0, 0, 0, 1);
      check("ret2_after_int", 32'({ctrl_o[4], ctrl_o[16], fetch_hold}), 32'b110);

      step(1, 6'd28, 0, 0, 0, 1);
      check("rti1_hold", 32'(fetch_hold), 32'd1);
      step(1, 6'd9, 0, 1, 0, 1);
      check("rti_flush_bubble", 32'({ctrl_o, ctrl_valid, fetch_hold}), 32'd0);
      step(0, 6'd0, 0, 0, 0, 1);
      check("no_rti2_after_flush", 32'({ctrl_o, ctrl_valid}), 32'd0);

      step(1, 6'd24, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         step(1, 6'd9, 1, 0, 1, 1);
         check("stall_frozen", 32'({ctrl_o, fetch_hold, int_ack}), {9'd0, 22'h120308, 1'b1} << 1);
      end
      step(0, 6'd0, 0, 0, 0, 1);
      check("call2_after_stall", 32'({ctrl_o[7], fetch_hold}), 32'b10);
      step(0, 6'd0, 0, 0, 0, 1);
      check("call2_once", 32'({ctrl_o, ctrl_valid}), 32'd0);

      step(1, 6'd32, 0, 0, 0, 1);
      check("opc32_illegal", 32'({ctrl_o, ctrl_valid, illegal}), 32'b11);
      step(1, 6'd25, 0, 0, 0, 1);
      check("ext_call2_illegal", 32'({ctrl_o, ctrl_valid, illegal}), 32'b11);
      step(1, 6'd9, 0, 0, 0, 1);
      check("illegal_clears", 32'(illegal), 32'd0);

      step(0, 6'd0, 0, 0, 1, 1);
      step(0, 6'd0, 0, 0, 0, 0);
      check("reset_in_int2", 32'({ctrl_o, ctrl_valid, fetch_hold, int_ack, illegal}), 32'd0);
      step(0, 6'd0, 0, 0, 0, 1);

      for (int i = 0; i < 3000; i++) begin
         logic [5:0] op;
         if ($urandom_range(0, 3) == 0) op = 6'(24 + 2 * $urandom_range(0, 2));
         else                          op = 6'($urandom_range(0, 63));
         step($urandom_range(0, 99) < 75, op, $urandom_range(0, 99) < 10,
              $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 12,
              $urandom_range(0, 99) != 0);
      end

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
